nubus_slave_block: RTL and testbench

//  Parametrised NuBus slave engine; successor of the single-word slave FSM.

---
 rtl/nubus_pkg.sv | 64 ++++++
 rtl/nubus_slave_block_if.sv | 32 +++
 rtl/nubus_addr_decode.sv | 32 +++
 rtl/nubus_slave_block.sv | 185 ++++++++++++++++++
 tb/tb_nubus_slave_block.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/nubus_pkg.sv
// Shared types and constants for the NuBus slave engine: FSM states,
// ack status codes, transfer-size codes and the block-length table.
package nubus_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WDATA,
    S_MEM,
    S_ACK
  } state_t;

  // Ack status {tm1n, tm0n} as driven on the bus
  localparam logic [1:0] ST_COMPLETE = 2'b00;
  localparam logic [1:0] ST_ERROR    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT  = 2'b10;
  localparam logic [1:0] ST_BEAT     = 2'b11;

  // Size codes {tm0n, a[1:0]}; any code with tm0n=0 is a byte access
  localparam logic [2:0] SZ_WORD    = 3'b100;
  localparam logic [2:0] SZ_BLOCK   = 3'b101;
  localparam logic [2:0] SZ_HALF_LO = 3'b110;
  localparam logic [2:0] SZ_HALF_HI = 3'b111;

  typedef struct packed {
    logic       ok;
    logic [3:0] lanes;
    logic [3:0] beats_m1;
  } size_t;

  // Block code a[5:2] to (beats - 1); the result doubles as the wrap mask.
  // Zero marks an illegal code.
  function automatic logic [3:0] block_beats_m1(input logic [3:0] code);
    case (code)
      4'b0001: return 4'd1;
      4'b0010: return 4'd3;
      4'b0100: return 4'd7;
      4'b1000: return 4'd15;
      default: return 4'd0;
    endcase
  endfunction

  function automatic size_t decode_size(input logic tm0n, input logic [5:0] a_lo);
    size_t r;
    r.ok       = 1'b1;
    r.lanes    = 4'b1111;
    r.beats_m1 = 4'd0;
    if (!tm0n) begin
      r.lanes = 4'b0001 << a_lo[1:0];
    end else begin
      case ({tm0n, a_lo[1:0]})
        SZ_WORD:    r.lanes = 4'b1111;
        SZ_HALF_LO: r.lanes = 4'b0011;
        SZ_HALF_HI: r.lanes = 4'b1100;
        SZ_BLOCK: begin
          r.beats_m1 = block_beats_m1(a_lo[5:2]);
          r.ok       = (r.beats_m1 != 4'd0);
        end
        default: r.ok = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/nubus_slave_block_if.sv
// NuBus-side and card-memory-side signals of the slave engine.
// The slave modport is the engine's view; master is the pads/memory view.
interface nubus_slave_block_if;
  logic        nub_startn_i;
  logic        nub_tm1n_i;
  logic        nub_tm0n_i;
  logic [31:0] nub_adn_i;
  logic        slv_ackn_o;
  logic        slv_tm1n_o;
  logic        slv_tm0n_o;
  logic [31:0] slv_adn_o;
  logic        slv_adoe_o;
  logic        slv_ctloe_o;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_write;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport slave (
    input  nub_startn_i, nub_tm1n_i, nub_tm0n_i, nub_adn_i, mem_ready, mem_rdata,
    output slv_ackn_o, slv_tm1n_o, slv_tm0n_o, slv_adn_o, slv_adoe_o, slv_ctloe_o,
           mem_valid, mem_addr, mem_wdata, mem_write
  );

  modport master (
    output nub_startn_i, nub_tm1n_i, nub_tm0n_i, nub_adn_i, mem_ready, mem_rdata,
    input  slv_ackn_o, slv_tm1n_o, slv_tm0n_o, slv_adn_o, slv_adoe_o, slv_ctloe_o,
           mem_valid, mem_addr, mem_wdata, mem_write
  );
endinterface

// File: rtl/nubus_addr_decode.sv
// Combinational slot / expansion-window match on the true address a[31:24].
// Slot space has priority; among windows the lowest index wins.
module nubus_addr_decode #(
  parameter logic [3:0]             SLOTS_ADDRESS = 4'hF,
  parameter int                     N_WINDOWS     = 2,
  parameter logic [8*N_WINDOWS-1:0] WIN_BASE      = {N_WINDOWS{8'h00}},
  parameter logic [8*N_WINDOWS-1:0] WIN_MASK      = {N_WINDOWS{8'hC0}}
) (
  input  logic [3:0]           idn,
  input  logic [7:0]           a_hi,
  output logic                 hit,
  output logic [N_WINDOWS-1:0] win
);

  // Scan windows from the top down so the lowest matching index is kept
  always_comb begin
    hit = 1'b0;
    win = '0;
    if (a_hi == {SLOTS_ADDRESS, ~idn}) begin
      hit = 1'b1;
    end else begin
      for (int i = N_WINDOWS - 1; i >= 0; i--) begin
        if ((a_hi & WIN_MASK[8*i +: 8]) == (WIN_BASE[8*i +: 8] & WIN_MASK[8*i +: 8])) begin
          hit    = 1'b1;
          win    = '0;
          win[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/nubus_slave_block.sv
// NuBus slave engine: decodes slot/window space, sizes byte lanes, runs
// single and wrapping block transfers against the card memory bus and
// returns NuBus completion status.
// Build option NUBUS_SLAVE_TIMEOUT_EN: abort a memory access with TIMEOUT
// status after TIMEOUT_CYCLES cycles without mem_ready.
module nubus_slave_block
  import nubus_pkg::*;
#(
  parameter logic [3:0]             SLOTS_ADDRESS  = 4'hF,
  parameter int                     N_WINDOWS      = 2,
  parameter logic [8*N_WINDOWS-1:0] WIN_BASE       = {N_WINDOWS{8'h00}},
  parameter logic [8*N_WINDOWS-1:0] WIN_MASK       = {N_WINDOWS{8'hC0}},
  parameter int                     TIMEOUT_CYCLES = 255
) (
  input  logic                 nub_clk,
  input  logic                 nub_reset,
  input  logic [3:0]           nub_idn,
  nubus_slave_block_if.slave   bus,
  output logic                 slv_busy_o,
  output logic [N_WINDOWS-1:0] slv_win_o
);

`ifdef NUBUS_SLAVE_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  state_t                 state_q, state_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [3:0]             lanes_q, lanes_d;
  logic                   write_q, write_d;
  logic [1:0]             status_q, status_d;
  logic [3:0]             beats_q, beats_d;
  logic [3:0]             mask_q, mask_d;
  logic [N_WINDOWS-1:0]   win_q, win_d;
  logic [15:0]            cnt_q, cnt_d;

  logic [31:0]            a_in;
  logic                   hit;
  logic [N_WINDOWS-1:0]   win_hit;
  size_t                  sz;

  assign a_in = ~bus.nub_adn_i;
  assign sz   = decode_size(bus.nub_tm0n_i, a_in[5:0]);

  nubus_addr_decode #(
    .SLOTS_ADDRESS (SLOTS_ADDRESS),
    .N_WINDOWS     (N_WINDOWS),
    .WIN_BASE      (WIN_BASE),
    .WIN_MASK      (WIN_MASK)
  ) u_decode (
    .idn  (nub_idn),
    .a_hi (a_in[31:24]),
    .hit  (hit),
    .win  (win_hit)
  );

  // State and transaction context registers
  always_ff @(posedge nub_clk) begin
    if (nub_reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      lanes_q  <= '0;
      write_q  <= 1'b0;
      status_q <= ST_BEAT;
      beats_q  <= '0;
      mask_q   <= '0;
      win_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      lanes_q  <= lanes_d;
      write_q  <= write_d;
      status_q <= status_d;
      beats_q  <= beats_d;
      mask_q   <= mask_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and context update: start decode, data capture, beat sequencing
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    lanes_d  = lanes_q;
    write_d  = write_q;
    status_d = status_q;
    beats_d  = beats_q;
    mask_d   = mask_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (!bus.nub_startn_i && hit) begin
          addr_d  = {a_in[31:2], 2'b00};
          write_d = !bus.nub_tm1n_i;
          lanes_d = sz.lanes;
          beats_d = sz.beats_m1;
          mask_d  = sz.beats_m1;
          win_d   = win_hit;
          cnt_d   = '0;
          if (!sz.ok) begin
            status_d = ST_ERROR;
            state_d  = S_ACK;
          end else if (!bus.nub_tm1n_i) begin
            state_d = S_WDATA;
          end else begin
            state_d = S_MEM;
          end
        end
      end
      S_WDATA: begin
        wdata_d = ~bus.nub_adn_i;
        cnt_d   = '0;
        state_d = S_MEM;
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          if (!write_q) rdata_d = bus.mem_rdata;
          status_d = (beats_q == 4'd0) ? ST_COMPLETE : ST_BEAT;
          state_d  = S_ACK;
        end else if (TIMEOUT_EN && (cnt_q == 16'(TIMEOUT_CYCLES - 1))) begin
          status_d = ST_TIMEOUT;
          state_d  = S_ACK;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_ACK: begin
        if (status_q == ST_BEAT) begin
          beats_d     = beats_q - 4'd1;
          addr_d[5:2] = (addr_q[5:2] & ~mask_q) | ((addr_q[5:2] + 4'd1) & mask_q);
          cnt_d       = '0;
          state_d     = write_q ? S_WDATA : S_MEM;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus and memory strobes decoded from the current state
  always_comb begin
    bus.slv_ackn_o  = 1'b1;
    bus.slv_tm1n_o  = 1'b1;
    bus.slv_tm0n_o  = 1'b1;
    bus.slv_adoe_o  = 1'b0;
    bus.slv_ctloe_o = 1'b0;
    bus.mem_valid   = 1'b0;
    bus.mem_write   = 4'b0000;
    case (state_q)
      S_MEM: begin
        bus.mem_valid = 1'b1;
        bus.mem_write = write_q ? lanes_q : 4'b0000;
      end
      S_ACK: begin
        bus.slv_ackn_o  = 1'b0;
        bus.slv_tm1n_o  = status_q[1];
        bus.slv_tm0n_o  = status_q[0];
        bus.slv_ctloe_o = 1'b1;
        bus.slv_adoe_o  = !write_q;
      end
      default: ;
    endcase
  end

  assign bus.slv_adn_o = ~rdata_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign slv_busy_o    = (state_q != S_IDLE);
  assign slv_win_o     = win_q;

endmodule

// File: tb/tb_nubus_slave_block.sv
// Directed bench for nubus_slave_block: slot reads/writes, block wrap,
// window decode, size errors, memory stall / timeout and mid-transfer reset.
module tb_nubus_slave_block;

  logic       clk;
  logic       rst;
  logic [3:0] idn;
  logic       busy;
  logic [1:0] win;
  int         errors;
  int         checks;

  nubus_slave_block_if bus ();

  nubus_slave_block #(
    .SLOTS_ADDRESS  (4'hF),
    .N_WINDOWS      (2),
    .WIN_BASE       ({2{8'h00}}),
    .WIN_MASK       ({2{8'hC0}}),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .nub_clk    (clk),
    .nub_reset  (rst),
    .nub_idn    (idn),
    .bus        (bus),
    .slv_busy_o (busy),
    .slv_win_o  (win)
  );

  // Free-running card clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.nub_startn_i = 1'b1;
    bus.nub_tm1n_i   = 1'b1;
    bus.nub_tm0n_i   = 1'b1;
    bus.nub_adn_i    = 32'hFFFFFFFF;
    bus.mem_ready    = 1'b0;
    bus.mem_rdata    = 32'h0;
  endtask

  task automatic start(input logic [31:0] a, input logic tm1n, input logic tm0n);
    bus.nub_startn_i = 1'b0;
    bus.nub_tm1n_i   = tm1n;
    bus.nub_tm0n_i   = tm0n;
    bus.nub_adn_i    = ~a;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_idle();
    tick();
    tick();
    rst = 1'b0;
    checks++; if (bus.slv_ackn_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_ackn: got %b want 1", bus.slv_ackn_o); end
    checks++; if ({bus.slv_tm1n_o, bus.slv_tm0n_o} !== 2'b11) begin errors++; $display("[TB] FAIL rst_tm: got %b want 11", {bus.slv_tm1n_o, bus.slv_tm0n_o}); end
    checks++; if (bus.slv_adn_o !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL rst_adn: got %h want ffffffff", bus.slv_adn_o); end
    checks++; if ({bus.slv_adoe_o, bus.slv_ctloe_o, busy, win} !== 5'b0) begin errors++; $display("[TB] FAIL rst_oe_busy_win: got %b want 00000", {bus.slv_adoe_o, bus.slv_ctloe_o, busy, win}); end
    checks++; if ({bus.mem_valid, bus.mem_write} !== 5'b0) begin errors++; $display("[TB] FAIL rst_mem_ctl: got %b want 00000", {bus.mem_valid, bus.mem_write}); end
    checks++; if ({bus.mem_addr, bus.mem_wdata} !== 64'h0) begin errors++; $display("[TB] FAIL rst_mem_data: got %h want 0", {bus.mem_addr, bus.mem_wdata}); end
  endtask

  task automatic test_slot_read();
    start(32'hF1000010, 1'b1, 1'b1);
    tick();
    bus_idle();
    checks++; if (bus.mem_valid !== 1'b1) begin errors++; $display("[TB] FAIL rd_valid: got %b want 1", bus.mem_valid); end
    checks++; if (bus.mem_addr !== 32'hF1000010) begin errors++; $display("[TB] FAIL rd_addr: got %h want f1000010", bus.mem_addr); end
    checks++; if (bus.mem_write !== 4'b0000) begin errors++; $display("[TB] FAIL rd_write: got %b want 0000", bus.mem_write); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rd_busy: got %b want 1", busy); end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hCAFEBABE;
    tick();
    bus_idle();
    checks++; if (bus.slv_ackn_o !== 1'b0) begin errors++; $display("[TB] FAIL rd_ack: got %b want 0", bus.slv_ackn_o); end
    checks++; if ({bus.slv_tm1n_o, bus.slv_tm0n_o} !== 2'b00) begin errors++; $display("[TB] FAIL rd_status: got %b want 00", {bus.slv_tm1n_o, bus.slv_tm0n_o}); end
    checks++; if (bus.slv_adn_o !== 32'h35014541) begin errors++; $display("[TB] FAIL rd_data: got %h want 35014541", bus.slv_adn_o); end
    checks++; if ({bus.slv_adoe_o, bus.slv_ctloe_o, bus.mem_valid} !== 3'b110) begin errors++; $display("[TB] FAIL rd_oe: got %b want 110", {bus.slv_adoe_o, bus.slv_ctloe_o, bus.mem_valid}); end
    tick();
    checks++; if ({bus.slv_ackn_o, busy, bus.slv_ctloe_o} !== 3'b100) begin errors++; $display("[TB] FAIL rd_end: got %b want 100", {bus.slv_ackn_o, busy, bus.slv_ctloe_o}); end
  endtask

  task automatic test_write(input string name, input logic [31:0] a, input logic tm0n,
                            input logic [31:0] data, input logic [3:0] lanes);
    start(a, 1'b0, tm0n);
    tick();
    bus_idle();
    bus.nub_adn_i = ~data;
    checks++; if ({bus.mem_valid, busy} !== 2'b01) begin errors++; $display("[TB] FAIL %s_wdata_phase: got %b want 01", name, {bus.mem_valid, busy}); end
    tick();
    bus.nub_adn_i = 32'hFFFFFFFF;
    checks++; if (bus.mem_valid !== 1'b1) begin errors++; $display("[TB] FAIL %s_valid: got %b want 1", name, bus.mem_valid); end
    checks++; if (bus.mem_write !== lanes) begin errors++; $display("[TB] FAIL %s_lanes: got %b want %b", name, bus.mem_write, lanes); end
    checks++; if (bus.mem_wdata !== data) begin errors++; $display("[TB] FAIL %s_wdata: got %h want %h", name, bus.mem_wdata, data); end
    checks++; if (bus.mem_addr !== {a[31:2], 2'b00}) begin errors++; $display("[TB] FAIL %s_addr: got %h want %h", name, bus.mem_addr, {a[31:2], 2'b00}); end
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    checks++; if ({bus.slv_ackn_o, bus.slv_tm1n_o, bus.slv_tm0n_o, bus.slv_adoe_o, bus.slv_ctloe_o} !== 5'b00001) begin errors++; $display("[TB] FAIL %s_ack: got %b want 00001", name, {bus.slv_ackn_o, bus.slv_tm1n_o, bus.slv_tm0n_o, bus.slv_adoe_o, bus.slv_ctloe_o}); end
    tick();
  endtask

  task automatic test_block_read();
    logic [31:0] exp_addr [4];
    exp_addr[0] = 32'hF1000008;
    exp_addr[1] = 32'hF100000C;
    exp_addr[2] = 32'hF1000000;
    exp_addr[3] = 32'hF1000004;
    start(32'hF1000009, 1'b1, 1'b1);
    tick();
    bus_idle();
    for (int b = 0; b < 4; b++) begin
      checks++; if ({bus.mem_valid, bus.mem_addr} !== {1'b1, exp_addr[b]}) begin errors++; $display("[TB] FAIL blk_addr%0d: got %b/%h want 1/%h", b, bus.mem_valid, bus.mem_addr, exp_addr[b]); end
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'h1000 + b;
      tick();
      bus_idle();
      checks++; if ({bus.slv_ackn_o, bus.slv_tm1n_o, bus.slv_tm0n_o} !== ((b == 3) ? 3'b000 : 3'b011)) begin errors++; $display("[TB] FAIL blk_ack%0d: got %b want %b", b, {bus.slv_ackn_o, bus.slv_tm1n_o, bus.slv_tm0n_o}, (b == 3) ? 3'b000 : 3'b011); end
      checks++; if (bus.slv_adn_o !== ~(32'h1000 + b)) begin errors++; $display("[TB] FAIL blk_data%0d: got %h want %h", b, bus.slv_adn_o, ~(32'h1000 + b)); end
      tick();
    end
    checks++; if ({busy, bus.mem_valid, bus.slv_ackn_o} !== 3'b001) begin errors++; $display("[TB] FAIL blk_end: got %b want 001", {busy, bus.mem_valid, bus.slv_ackn_o}); end
  endtask

  task automatic test_window();
    start(32'h05000020, 1'b1, 1'b1);
    tick();
    bus_idle();
    checks++; if (win !== 2'b01) begin errors++; $display("[TB] FAIL win_onehot: got %b want 01", win); end
    checks++; if ({bus.mem_valid, bus.mem_addr} !== {1'b1, 32'h05000020}) begin errors++; $display("[TB] FAIL win_addr: got %b/%h want 1/05000020", bus.mem_valid, bus.mem_addr); end
    bus.mem_ready = 1'b1;
    tick();
    bus_idle();
    checks++; if ({bus.slv_ackn_o, bus.slv_tm1n_o, bus.slv_tm0n_o} !== 3'b000) begin errors++; $display("[TB] FAIL win_ack: got %b want 000", {bus.slv_ackn_o, bus.slv_tm1n_o, bus.slv_tm0n_o}); end
    tick();
    start(32'hE0000000, 1'b1, 1'b1);
    tick();
    bus_idle();
    checks++; if ({busy, bus.mem_valid} !== 2'b00) begin errors++; $display("[TB] FAIL miss_busy: got %b want 00", {busy, bus.mem_valid}); end
    tick();
    checks++; if ({bus.slv_ackn_o, bus.slv_ctloe_o} !== 2'b10) begin errors++; $display("[TB] FAIL miss_ack: got %b want 10", {bus.slv_ackn_o, bus.slv_ctloe_o}); end
  endtask

  task automatic test_bad_block();
    start(32'hF100000D, 1'b1, 1'b1);
    tick();
    bus_idle();
    checks++; if ({bus.slv_ackn_o, bus.slv_tm1n_o, bus.slv_tm0n_o, bus.slv_ctloe_o} !== 4'b0011) begin errors++; $display("[TB] FAIL err_ack: got %b want 0011", {bus.slv_ackn_o, bus.slv_tm1n_o, bus.slv_tm0n_o, bus.slv_ctloe_o}); end
    checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("[TB] FAIL err_valid: got %b want 0", bus.mem_valid); end
    tick();
    checks++; if ({busy, bus.mem_valid, bus.slv_ackn_o} !== 3'b001) begin errors++; $display("[TB] FAIL err_end: got %b want 001", {busy, bus.mem_valid, bus.slv_ackn_o}); end
  endtask

  task automatic test_stall();
    int n;
    start(32'hF1000040, 1'b1, 1'b1);
    tick();
    bus_idle();
    n = 0;
    while (bus.mem_valid === 1'b1 && bus.slv_ackn_o === 1'b1 && n < 40) begin
      n++;
      tick();
    end
`ifdef NUBUS_SLAVE_TIMEOUT_EN
    checks++; if (n !== 8) begin errors++; $display("[TB] FAIL to_cycles: got %0d want 8", n); end
    checks++; if ({bus.slv_ackn_o, bus.slv_tm1n_o, bus.slv_tm0n_o, bus.mem_valid} !== 4'b0100) begin errors++; $display("[TB] FAIL to_ack: got %b want 0100", {bus.slv_ackn_o, bus.slv_tm1n_o, bus.slv_tm0n_o, bus.mem_valid}); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL to_end: got %b want 0", busy); end
`else
    checks++; if (n !== 40) begin errors++; $display("[TB] FAIL stall_cycles: got %0d want 40", n); end
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    checks++; if ({bus.slv_ackn_o, bus.slv_tm1n_o, bus.slv_tm0n_o} !== 3'b000) begin errors++; $display("[TB] FAIL stall_ack: got %b want 000", {bus.slv_ackn_o, bus.slv_tm1n_o, bus.slv_tm0n_o}); end
    tick();
`endif
  endtask

  task automatic test_reset_mid_mem();
    start(32'hF1000080, 1'b1, 1'b1);
    tick();
    bus_idle();
    tick();
    checks++; if (bus.mem_valid !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pre: got %b want 1", bus.mem_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({bus.mem_valid, busy, bus.slv_ackn_o, bus.slv_ctloe_o, bus.slv_adoe_o} !== 5'b00100) begin errors++; $display("[TB] FAIL midrst_ctl: got %b want 00100", {bus.mem_valid, busy, bus.slv_ackn_o, bus.slv_ctloe_o, bus.slv_adoe_o}); end
    checks++; if ({bus.mem_addr, bus.mem_wdata, bus.slv_adn_o} !== {64'h0, 32'hFFFFFFFF}) begin errors++; $display("[TB] FAIL midrst_data: got %h want 0/ffffffff", {bus.mem_addr, bus.mem_wdata, bus.slv_adn_o}); end
    tick();
  endtask

  // Scenario sequence
  initial begin
    errors = 0;
    checks = 0;
    idn    = 4'hE;
    test_reset();
    test_slot_read();
    test_write("byte", 32'hF1000003, 1'b0, 32'h000000AB, 4'b1000);
    test_write("half", 32'hF1000107, 1'b1, 32'h5A5A1234, 4'b1100);
    test_block_read();
    test_window();
    test_bad_block();
    test_stall();
    test_reset_mid_mem();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
